// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: per-lane register file read, completion bypass at
// accept time, and a two-entry (head + skid) buffer per lane that decouples
// each lane's execution pipeline from the others.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is a registered "fewer than two entries held"
// signal and never depends on in_valid. out_valid means the head entry is
// occupied; head contents do not change while out_valid && !out_ready.
module operand_fetch_stage #(
    parameter int LANES       = 3,
    parameter int SRCS        = 4,
    parameter int PREG_W      = 5,
    parameter int DATA_W      = 8,
    parameter int CMPLT_PORTS = 6,
    parameter int PAYLOAD_W   = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [LANES-1:0]                in_valid,
    output logic [LANES-1:0]                in_ready,
    input  logic [LANES*SRCS*PREG_W-1:0]    in_src_tags,
    input  logic [LANES*PAYLOAD_W-1:0]      in_payload,
    output logic [LANES*SRCS*PREG_W-1:0]    rf_rd_addr,
    input  logic [LANES*SRCS*DATA_W-1:0]    rf_rd_data,
    input  logic [CMPLT_PORTS-1:0]          cmplt_valid,
    input  logic [CMPLT_PORTS*PREG_W-1:0]   cmplt_tag,
    input  logic [CMPLT_PORTS*DATA_W-1:0]   cmplt_val,
    output logic [LANES-1:0]                out_valid,
    input  logic [LANES-1:0]                out_ready,
    output logic [LANES*SRCS*DATA_W-1:0]    out_operands,
    output logic [LANES*PAYLOAD_W-1:0]      out_payload
);

    localparam int OPS_W = SRCS * DATA_W;

    // Register file is read directly with the incoming source tags.
    assign rf_rd_addr = in_src_tags;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [1:0]           r_count;
        logic                 r_in_ready;
        logic [OPS_W-1:0]     r_head_ops;
        logic [OPS_W-1:0]     r_skid_ops;
        logic [PAYLOAD_W-1:0] r_head_pay;
        logic [PAYLOAD_W-1:0] r_skid_pay;

        logic [OPS_W-1:0]     w_capt_ops;
        logic [PAYLOAD_W-1:0] w_in_pay;
        logic                 w_accept;
        logic                 w_deq;
        logic [1:0]           w_count_nxt;
        logic                 w_load_head_new;
        logic                 w_load_head_skid;
        logic                 w_load_skid;

        assign w_in_pay = in_payload[l*PAYLOAD_W +: PAYLOAD_W];

        // Operand selection per source: tag 0 reads as zero, otherwise the
        // lowest-numbered matching completion port wins over the RF value.
        // Ports are scanned from high to low so the lowest match is written last.
        always_comb begin
            w_capt_ops = '0;
            for (int s = 0; s < SRCS; s++) begin
                w_capt_ops[s*DATA_W +: DATA_W] = rf_rd_data[(l*SRCS+s)*DATA_W +: DATA_W];
                for (int p = CMPLT_PORTS - 1; p >= 0; p--) begin
                    if (cmplt_valid[p] &&
                        (cmplt_tag[p*PREG_W +: PREG_W] == in_src_tags[(l*SRCS+s)*PREG_W +: PREG_W])) begin
                        w_capt_ops[s*DATA_W +: DATA_W] = cmplt_val[p*DATA_W +: DATA_W];
                    end
                end
                if (in_src_tags[(l*SRCS+s)*PREG_W +: PREG_W] == '0) begin
                    w_capt_ops[s*DATA_W +: DATA_W] = '0;
                end
            end
        end

        // Flush suppresses acceptance so nothing presented during it survives.
        assign w_accept = in_valid[l] & r_in_ready & ~flush;
        assign w_deq    = (r_count != 2'd0) & out_ready[l];

        // Occupancy update and the data moves it implies.
        always_comb begin
            w_count_nxt      = r_count;
            w_load_head_new  = 1'b0;
            w_load_head_skid = 1'b0;
            w_load_skid      = 1'b0;
            case (r_count)
                2'd0: begin
                    if (w_accept) begin
                        w_count_nxt     = 2'd1;
                        w_load_head_new = 1'b1;
                    end
                end
                2'd1: begin
                    if (w_accept && w_deq) begin
                        w_load_head_new = 1'b1;
                    end else if (w_accept) begin
                        w_count_nxt = 2'd2;
                        w_load_skid = 1'b1;
                    end else if (w_deq) begin
                        w_count_nxt = 2'd0;
                    end
                end
                2'd2: begin
                    // in_ready is low here, so only a dequeue can happen.
                    if (w_deq) begin
                        w_count_nxt      = 2'd1;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: begin
                    w_count_nxt = 2'd0;
                end
            endcase
            if (flush) begin
                w_count_nxt = 2'd0;
            end
        end

        // Occupancy and registered ready.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_count    <= 2'd0;
                r_in_ready <= 1'b1;
            end else begin
                r_count    <= w_count_nxt;
                r_in_ready <= (w_count_nxt != 2'd2);
            end
        end

        // Head and skid storage; captured values are frozen once written.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_head_ops <= '0;
                r_head_pay <= '0;
                r_skid_ops <= '0;
                r_skid_pay <= '0;
            end else if (!flush) begin
                if (w_load_head_new) begin
                    r_head_ops <= w_capt_ops;
                    r_head_pay <= w_in_pay;
                end else if (w_load_head_skid) begin
                    r_head_ops <= r_skid_ops;
                    r_head_pay <= r_skid_pay;
                end
                if (w_load_skid) begin
                    r_skid_ops <= w_capt_ops;
                    r_skid_pay <= w_in_pay;
                end
            end
        end

        assign in_ready[l]                             = r_in_ready;
        assign out_valid[l]                            = (r_count != 2'd0);
        assign out_operands[l*OPS_W +: OPS_W]          = r_head_ops;
        assign out_payload[l*PAYLOAD_W +: PAYLOAD_W]   = r_head_pay;
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: table of single-cycle capture vectors,
// hand sequences for skid fill, flush and mid-stream reset, then a random
// phase checked against per-lane expected queues.
module tb_operand_fetch_stage;

    localparam int L  = 3;
    localparam int S  = 4;
    localparam int PW = 5;
    localparam int DW = 8;
    localparam int CP = 6;
    localparam int YW = 32;
    localparam int EW = YW + S*DW;

    logic                         clk;
    logic                         rst;
    logic                         flush;
    logic [L-1:0]                 in_valid;
    logic [L-1:0]                 in_ready;
    logic [L-1:0][S-1:0][PW-1:0]  in_src_tags;
    logic [L-1:0][YW-1:0]         in_payload;
    logic [L-1:0][S-1:0][PW-1:0]  rf_rd_addr;
    logic [L-1:0][S-1:0][DW-1:0]  rf_rd_data;
    logic [CP-1:0]                cmplt_valid;
    logic [CP-1:0][PW-1:0]        cmplt_tag;
    logic [CP-1:0][DW-1:0]        cmplt_val;
    logic [L-1:0]                 out_valid;
    logic [L-1:0]                 out_ready;
    logic [L-1:0][S-1:0][DW-1:0]  out_operands;
    logic [L-1:0][YW-1:0]         out_payload;

    int total = 0;
    int bad   = 0;

    operand_fetch_stage #(
        .LANES(L), .SRCS(S), .PREG_W(PW), .DATA_W(DW), .CMPLT_PORTS(CP), .PAYLOAD_W(YW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src_tags(in_src_tags), .in_payload(in_payload),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .cmplt_valid(cmplt_valid), .cmplt_tag(cmplt_tag), .cmplt_val(cmplt_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operands(out_operands), .out_payload(out_payload)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [L-1:0]                vld;
        logic [L-1:0][S-1:0][PW-1:0] tag;
        logic [L-1:0][S-1:0][DW-1:0] rf;
        logic [CP-1:0]               cv;
        logic [CP-1:0][PW-1:0]       ct;
        logic [CP-1:0][DW-1:0]       cval;
        logic [L-1:0][S-1:0][DW-1:0] exp_ops;
    } vec_t;

    localparam int NV = 5;
    vec_t vt[NV];

    // scoreboard: one expected queue per lane, entries are {payload, operands}
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];

    function automatic int q_size(int l);
        case (l)
            0: return exp_q0.size();
            1: return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [EW-1:0] q_front(int l);
        case (l)
            0: return exp_q0[0];
            1: return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    task automatic q_push(input int l, input logic [EW-1:0] v);
        case (l)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    task automatic q_pop(input int l);
        case (l)
            0: exp_q0.delete(0);
            1: exp_q1.delete(0);
            default: exp_q2.delete(0);
        endcase
    endtask

    task automatic q_clear();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        in_valid    = '0;
        in_src_tags = '0;
        in_payload  = '0;
        rf_rd_data  = '0;
        cmplt_valid = '0;
        cmplt_tag   = '0;
        cmplt_val   = '0;
    endtask

    // expected operand from first principles: tag 0 -> 0, lowest matching port, else RF
    function automatic logic [DW-1:0] model_op(int l, int s);
        if (in_src_tags[l][s] == '0) return '0;
        for (int p = 0; p < CP; p++) begin
            if (cmplt_valid[p] && cmplt_tag[p] == in_src_tags[l][s]) return cmplt_val[p];
        end
        return rf_rd_data[l][s];
    endfunction

    // streaming op for lanes 0 and 1, numbered by c
    task automatic drive_stream(input int c);
        for (int l = 0; l < 2; l++) begin
            in_valid[l]   = 1'b1;
            in_payload[l] = 32'h5000_0000 + c*16 + l;
            for (int s = 0; s < S; s++) begin
                in_src_tags[l][s] = PW'(l*4 + s + 1);
                rf_rd_data[l][s]  = DW'(c*8 + l*4 + s);
            end
        end
    endtask

    task automatic check_stream(input int c);
        logic [S-1:0][DW-1:0] e;
        for (int l = 0; l < 2; l++) begin
            for (int s = 0; s < S; s++) e[s] = DW'(c*8 + l*4 + s);
            chk($sformatf("stream_valid_l%0d_c%0d", l, c), 128'(out_valid[l]), 128'(1'b1));
            chk($sformatf("stream_pay_l%0d_c%0d", l, c), 128'(out_payload[l]), 128'(32'h5000_0000 + c*16 + l));
            chk($sformatf("stream_ops_l%0d_c%0d", l, c), 128'(out_operands[l]), 128'(e));
        end
    endtask

    task automatic set_lane2(input logic [YW-1:0] pay, input logic [DW-1:0] base);
        in_valid[2]   = 1'b1;
        in_payload[2] = pay;
        for (int s = 0; s < S; s++) begin
            in_src_tags[2][s] = PW'(20 + s);
            rf_rd_data[2][s]  = base + DW'(s);
        end
    endtask

    initial begin
        logic [S-1:0][DW-1:0] ops_a;
        logic [S-1:0][DW-1:0] ops_b;
        logic [S-1:0][DW-1:0] ops_e;
        logic                 deq;
        logic                 acc;

        // vector table: single-cycle capture, all pipelines ready
        foreach (vt[v]) begin
            vt[v].vld = '0; vt[v].tag = '0; vt[v].rf = '0;
            vt[v].cv = '0; vt[v].ct = '0; vt[v].cval = '0; vt[v].exp_ops = '0;
        end
        // basic fetch: tags {3,4,0,7}; RF data under tag 0 must not leak
        vt[0].vld        = 3'b001;
        vt[0].tag[0]     = {5'd7, 5'd0, 5'd4, 5'd3};
        vt[0].rf[0]      = {8'h77, 8'h99, 8'h22, 8'h11};
        vt[0].exp_ops[0] = {8'h77, 8'h00, 8'h22, 8'h11};
        // bypass priority, invalid-port ignore, tag-0 no bypass, multi-lane
        vt[1].vld        = 3'b111;
        vt[1].cv         = 6'b110101;
        vt[1].ct         = {5'd10, 5'd9, 5'd3, 5'd9, 5'd12, 5'd0};
        vt[1].cval       = {8'h3C, 8'h5A, 8'h33, 8'hA5, 8'hEE, 8'hFF};
        vt[1].tag[0]     = {5'd4, 5'd3, 5'd2, 5'd1};
        vt[1].rf[0]      = {8'h44, 8'h33, 8'h22, 8'h11};
        vt[1].exp_ops[0] = {8'h44, 8'h33, 8'h22, 8'h11};
        vt[1].tag[1]     = {5'd12, 5'd0, 5'd10, 5'd9};
        vt[1].rf[1]      = {8'h66, 8'h77, 8'h44, 8'h00};
        vt[1].exp_ops[1] = {8'h66, 8'h00, 8'h3C, 8'hA5};
        vt[1].tag[2]     = {5'd0, 5'd10, 5'd3, 5'd9};
        vt[1].rf[2]      = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        vt[1].exp_ops[2] = {8'h00, 8'h3C, 8'hBB, 8'hA5};
        // highest-numbered tag and ports 0/5
        vt[2].vld        = 3'b100;
        vt[2].cv         = 6'b100001;
        vt[2].ct         = {5'd31, 5'd0, 5'd0, 5'd0, 5'd31, 5'd2};
        vt[2].cval       = {8'h7E, 8'h00, 8'h00, 8'h00, 8'h01, 8'h80};
        vt[2].tag[2]     = {5'd2, 5'd31, 5'd1, 5'd31};
        vt[2].rf[2]      = {8'h13, 8'h12, 8'h11, 8'h10};
        vt[2].exp_ops[2] = {8'h80, 8'h7E, 8'h11, 8'h7E};
        // all ports busy with non-matching tags; lane 0 all tag 0
        vt[3].vld        = 3'b111;
        vt[3].cv         = 6'b111111;
        vt[3].ct         = {5'd10, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5};
        vt[3].cval       = {8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
        vt[3].rf[0]      = {8'h5A, 8'h5A, 8'h5A, 8'h5A};
        vt[3].tag[1]     = {5'd31, 5'd30, 5'd29, 5'd28};
        vt[3].rf[1]      = {8'hF4, 8'hF3, 8'hF2, 8'hF1};
        vt[3].exp_ops[1] = {8'hF4, 8'hF3, 8'hF2, 8'hF1};
        vt[3].tag[2]     = {5'd1, 5'd1, 5'd1, 5'd1};
        vt[3].rf[2]      = {8'h04, 8'h03, 8'h02, 8'h01};
        vt[3].exp_ops[2] = {8'h04, 8'h03, 8'h02, 8'h01};
        // nothing offered: pipeline drains
        vt[4].vld        = 3'b000;

        // reset
        idle_inputs();
        out_ready = '0;
        rst = 1'b0;
        repeat (3) step();
        chk("reset_out_valid", 128'(out_valid), 128'(3'b000));
        chk("reset_in_ready", 128'(in_ready), 128'(3'b111));
        chk("reset_operands", 128'(out_operands), 128'(0));
        chk("reset_payload", 128'(out_payload), 128'(0));
        rst = 1'b1;
        step();

        // table-driven vectors
        out_ready = 3'b111;
        for (int v = 0; v < NV; v++) begin
            in_valid    = vt[v].vld;
            in_src_tags = vt[v].tag;
            rf_rd_data  = vt[v].rf;
            cmplt_valid = vt[v].cv;
            cmplt_tag   = vt[v].ct;
            cmplt_val   = vt[v].cval;
            for (int l = 0; l < L; l++) in_payload[l] = 32'hA000_0000 | (v << 8) | l;
            #1;
            chk($sformatf("rf_addr_v%0d", v), 128'(rf_rd_addr), 128'(vt[v].tag));
            step();
            chk($sformatf("vec_out_valid_v%0d", v), 128'(out_valid), 128'(vt[v].vld));
            for (int l = 0; l < L; l++) begin
                if (vt[v].vld[l]) begin
                    chk($sformatf("vec_ops_v%0d_l%0d", v, l), 128'(out_operands[l]), 128'(vt[v].exp_ops[l]));
                    chk($sformatf("vec_pay_v%0d_l%0d", v, l), 128'(out_payload[l]),
                        128'(32'hA000_0000 | (v << 8) | l));
                end
            end
        end
        idle_inputs();
        step();

        // skid fill on lane 2 while lanes 0 and 1 stream
        for (int s = 0; s < S; s++) begin
            ops_a[s] = 8'h30 + DW'(s);
            ops_b[s] = 8'h40 + DW'(s);
        end
        out_ready = 3'b011;
        drive_stream(0);
        set_lane2(32'hAAAA_0001, 8'h30);
        step();
        check_stream(0);
        chk("skid_ready_after_a", 128'(in_ready[2]), 128'(1'b1));
        chk("skid_pay_a", 128'(out_payload[2]), 128'(32'hAAAA_0001));
        drive_stream(1);
        set_lane2(32'hBBBB_0002, 8'h40);
        step();
        check_stream(1);
        chk("skid_ready_full", 128'(in_ready[2]), 128'(1'b0));
        chk("skid_hold_ops_a", 128'(out_operands[2]), 128'(ops_a));
        for (int c = 2; c < 4; c++) begin
            drive_stream(c);
            set_lane2(32'hCCCC_0003, 8'h50);
            step();
            check_stream(c);
            chk($sformatf("skid_full_c%0d", c), 128'(in_ready[2]), 128'(1'b0));
            chk($sformatf("skid_stable_pay_c%0d", c), 128'(out_payload[2]), 128'(32'hAAAA_0001));
            chk($sformatf("skid_stable_ops_c%0d", c), 128'(out_operands[2]), 128'(ops_a));
        end
        drive_stream(4);
        in_valid[2] = 1'b0;
        out_ready   = 3'b111;
        step();
        check_stream(4);
        chk("skid_b_valid", 128'(out_valid[2]), 128'(1'b1));
        chk("skid_b_pay", 128'(out_payload[2]), 128'(32'hBBBB_0002));
        chk("skid_b_ops", 128'(out_operands[2]), 128'(ops_b));
        chk("skid_ready_back", 128'(in_ready[2]), 128'(1'b1));
        drive_stream(5);
        step();
        check_stream(5);
        chk("skid_drained", 128'(out_valid[2]), 128'(1'b0));
        idle_inputs();
        step();

        // flush with lane 0 holding 2 and lane 1 holding 1
        out_ready = 3'b000;
        drive_stream(10);
        step();
        idle_inputs();
        drive_stream(11);
        in_valid = 3'b001;
        step();
        chk("flush_pre_ready", 128'(in_ready), 128'(3'b110));
        chk("flush_pre_valid", 128'(out_valid), 128'(3'b011));
        drive_stream(12);
        set_lane2(32'hF1F1_0000, 8'h60);
        flush = 1'b1;
        step();
        idle_inputs();
        chk("flush_out_valid", 128'(out_valid), 128'(3'b000));
        chk("flush_in_ready", 128'(in_ready), 128'(3'b111));
        step();
        chk("flush_no_ghost", 128'(out_valid), 128'(3'b000));

        // asynchronous reset while lane 1 is full
        out_ready = 3'b101;
        drive_stream(20);
        in_valid = 3'b010;
        step();
        drive_stream(21);
        in_valid = 3'b010;
        step();
        idle_inputs();
        chk("rst_pre_full", 128'(in_ready[1]), 128'(1'b0));
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_valid", 128'(out_valid), 128'(3'b000));
        chk("rst_async_ready", 128'(in_ready), 128'(3'b111));
        chk("rst_async_ops", 128'(out_operands), 128'(0));
        chk("rst_async_pay", 128'(out_payload), 128'(0));
        step();
        rst = 1'b1;
        step();

        // random traffic against per-lane expected queues
        q_clear();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int l = 0; l < L; l++) begin
                chk($sformatf("rnd_valid_l%0d", l), 128'(out_valid[l]), 128'(q_size(l) > 0));
                chk($sformatf("rnd_ready_l%0d", l), 128'(in_ready[l]), 128'(q_size(l) < 2));
                if (q_size(l) > 0)
                    chk($sformatf("rnd_head_l%0d", l), 128'({out_payload[l], out_operands[l]}), 128'(q_front(l)));
            end
            flush = ($urandom_range(0, 39) == 0);
            for (int l = 0; l < L; l++) begin
                in_valid[l]   = ($urandom_range(0, 3) != 0);
                out_ready[l]  = ($urandom_range(0, 2) != 0);
                in_payload[l] = $urandom;
                for (int s = 0; s < S; s++) begin
                    in_src_tags[l][s] = PW'($urandom_range(0, 9));
                    rf_rd_data[l][s]  = DW'($urandom);
                end
            end
            for (int p = 0; p < CP; p++) begin
                cmplt_valid[p] = $urandom_range(0, 1);
                cmplt_tag[p]   = PW'($urandom_range(0, 9));
                cmplt_val[p]   = DW'($urandom);
            end
            if (flush) begin
                q_clear();
            end else begin
                for (int l = 0; l < L; l++) begin
                    deq = (q_size(l) > 0) && out_ready[l];
                    acc = in_valid[l] && (q_size(l) < 2);
                    for (int s = 0; s < S; s++) ops_e[s] = model_op(l, s);
                    if (deq) q_pop(l);
                    if (acc) q_push(l, {in_payload[l], ops_e});
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Parametrised successor to the fixed three-slot execute front end.
- Accepts up to LANES renamed ops per cycle and drives the physical register file read addresses.
- Captures operands with same-cycle completion bypass, then presents each lane to its execution pipeline through an independent valid/ready interface.
- Each lane has a 2-entry skid buffer, so back-pressure from one pipeline never stalls other lanes.

Parameters:
- LANES, 3, number of independent issue lanes.
- SRCS, 4, source operand tags per lane.
- PREG_W, 5, physical register tag width.
- DATA_W, 8, operand data width.
- CMPLT_PORTS, 6, number of completion/writeback ports snooped for bypass.
- PAYLOAD_W, 32, opaque per-op payload (opcode, ROB entry, dest tags, immediate), passed through unmodified.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all buffered ops.
- in_valid  in  LANES  lane l carries an op.
- in_ready  out  LANES  lane l can accept; registered, not a function of in_valid.
- in_src_tags  in  LANES*SRCS*PREG_W  source tags; lane l, src s at bits [(l*SRCS+s)*PREG_W +: PREG_W].
- in_payload  in  LANES*PAYLOAD_W  pass-through payload.
- rf_rd_addr  out  LANES*SRCS*PREG_W  equals in_src_tags, combinational.
- rf_rd_data  in  LANES*SRCS*DATA_W  combinational register file read data, same cycle.
- cmplt_valid  in  CMPLT_PORTS  completion port p writes this cycle.
- cmplt_tag  in  CMPLT_PORTS*PREG_W  completion tags.
- cmplt_val  in  CMPLT_PORTS*DATA_W  completion values.
- out_valid  out  LANES  lane l holds an op for its pipeline.
- out_ready  in  LANES  lane l pipeline accepts.
- out_operands  out  LANES*SRCS*DATA_W  captured operands, same packing as rf_rd_data.
- out_payload  out  LANES*PAYLOAD_W  payload of head entry.

Behaviour:
- Accept on lane l when in_valid[l] && in_ready[l]; dequeue when out_valid[l] && out_ready[l].
- Operand capture at accept, per source:
  - tag == 0: value 0; no read, no bypass.
  - else if any cmplt_valid[p] && cmplt_tag[p] == tag: cmplt_val of the lowest-index matching p.
  - else: rf_rd_data.
- Captured operands are never updated while buffered.
- Per-lane buffer: head register plus one skid register, count 0..2.
  - in_ready[l] = (count < 2), registered.
  - Latency: accept in cycle N -> out_valid[l] = 1 in cycle N+1 when count was 0.
  - Throughput: 1 op/cycle/lane with out_ready held high.
- Count transitions per lane:
  - 0 + accept -> 1.
  - 1 + accept + dequeue -> 1 (new op goes to head).
  - 1 + accept, no dequeue -> 2 (op to skid; in_ready falls next cycle).
  - 1 + dequeue -> 0.
  - 2 + dequeue -> 1 (skid moves to head).
  - Accept while count == 2 is impossible, because in_ready is already 0.
- Ordering: strictly FIFO per lane; no cross-lane ordering is enforced.
- Flush: next cycle all counts are 0, out_valid is all 0 and in_ready is all 1. Ops presented during the flush cycle are dropped. Flush overrides a simultaneous accept.
- Reset (rst low, asynchronous, including mid-operation): counts 0, out_valid 0, in_ready all 1, out_operands 0, out_payload 0.
- Output stability: out_operands and out_payload are held stable while out_valid && !out_ready.

Test Plan:
- Reset/idle: drive rst low mid-stream with lane 1 count 2 -> out_valid = 000 and in_ready = 111 immediately; outputs 0.
- Basic fetch: lane 0 tags {3,4,0,7}, rf data {0x11,0x22,xx,0x77}, out_ready = 1 -> next cycle out_operands lane 0 = {0x11,0x22,0x00,0x77}, payload matches.
- Bypass priority: tag 9 requested; cmplt port 2 = 9/0xA5 and port 4 = 9/0x5A in the same cycle; rf = 0x00 -> operand = 0xA5.
- Skid fill: lane 2 out_ready = 0, accept ops A, B back-to-back -> in_ready[2] = 0 from cycle 3. Release out_ready -> A then B in order, in_ready returns 1. Lanes 0 and 1 keep streaming at 1/cycle throughout.
- Flush: lanes 0 and 1 holding 2 and 1 entries; assert flush with in_valid = 111 -> next cycle out_valid = 000, nothing from the flush cycle appears.
- Parameter sweep: LANES = 1, SRCS = 2, DATA_W = 16, random valid/ready for 10k cycles -> a scoreboard matches per-lane order and operand values.
